// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if
// Signal bundle between the game sequencer and the bird/pipe datapath.
//   master : the sequencer (flappy_game_ctrl). It receives the button and the
//            datapath events, and drives state, strobes, gap select and scores.
//   slave  : the datapath side (or a testbench standing in for it).
interface flappy_game_ctrl_if;
    logic       jump;
    logic       collide;
    logic       out_of_bounds;
    logic       pass;
    logic       pipe_wrap;
    logic [1:0] state;
    logic       play_en;
    logic       clear;
    logic       fall_tick;
    logic       pipe_tick;
    logic       flap;
    logic [2:0] gap_sel;
    logic [7:0] score_bcd;
    logic [7:0] best_bcd;

    modport master (
        input  jump, collide, out_of_bounds, pass, pipe_wrap,
        output state, play_en, clear, fall_tick, pipe_tick, flap,
               gap_sel, score_bcd, best_bcd
    );

    modport slave (
        output jump, collide, out_of_bounds, pass, pipe_wrap,
        input  state, play_en, clear, fall_tick, pipe_tick, flap,
               gap_sel, score_bcd, best_bcd
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// Game sequencer for the 8x8 Flappy Bird datapath: the IDLE/CLEAR/PLAY/OVER
// machine, fall and pipe prescalers, jump edge detect, LFSR gap selection and
// the BCD score / best score. All outputs are registered.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : flappy_game_ctrl_if.master
//           in : jump, collide, out_of_bounds, pass, pipe_wrap
//           out: state, play_en, clear, fall_tick, pipe_tick, flap,
//                gap_sel, score_bcd, best_bcd
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first press after reset
// CLEAR | single cycle; datapath re-initialise, score and prescalers zeroed
// PLAY  | game running; ticks, flaps and scoring active
// OVER  | frozen; presses ignored until the hold counter saturates
module flappy_game_ctrl #(
    parameter int         FALL_DIV  = 50,
    parameter int         PIPE_DIV  = 40,
    parameter int         OVER_HOLD = 256,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    flappy_game_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam int PW = (PIPE_DIV > 1) ? $clog2(PIPE_DIV) : 1;
    localparam int HW = $clog2(OVER_HOLD + 1);
    localparam logic [FW-1:0] FALL_LAST = FW'(FALL_DIV - 1);
    localparam logic [PW-1:0] PIPE_LAST = PW'(PIPE_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(OVER_HOLD);

    state_t        st;
    logic          jump_q;
    logic [7:0]    lfsr;
    logic [FW-1:0] fall_cnt;
    logic [PW-1:0] pipe_cnt;
    logic [HW-1:0] hold_cnt;
    logic          rise;
    logic          hit;
    logic [7:0]    lfsr_nxt;

    assign rise      = bus.jump & ~jump_q;
    assign hit       = bus.collide | bus.out_of_bounds;
    // Right-shift Galois form of x^8+x^6+x^5+x^4+1.
    assign lfsr_nxt  = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    assign bus.state = st;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= S_IDLE;
            jump_q        <= 1'b1;
            lfsr          <= LFSR_SEED;
            fall_cnt      <= '0;
            pipe_cnt      <= '0;
            hold_cnt      <= '0;
            bus.play_en   <= 1'b0;
            bus.clear     <= 1'b0;
            bus.fall_tick <= 1'b0;
            bus.pipe_tick <= 1'b0;
            bus.flap      <= 1'b0;
            bus.gap_sel   <= 3'd0;
            bus.score_bcd <= 8'h00;
            bus.best_bcd  <= 8'h00;
        end else begin
            jump_q        <= bus.jump;
            lfsr          <= lfsr_nxt;
            bus.clear     <= 1'b0;
            bus.fall_tick <= 1'b0;
            bus.pipe_tick <= 1'b0;
            bus.flap      <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (rise) begin
                        st            <= S_CLEAR;
                        bus.clear     <= 1'b1;
                        bus.score_bcd <= 8'h00;
                        fall_cnt      <= '0;
                        pipe_cnt      <= '0;
                    end
                end

                S_CLEAR: begin
                    st          <= S_PLAY;
                    bus.play_en <= 1'b1;
                end

                S_PLAY: begin
                    if (bus.pipe_wrap)
                        bus.gap_sel <= lfsr[2:0];
                    if (hit) begin
                        // Collision beats a same-cycle pass; best compares the
                        // pre-increment score.
                        st          <= S_OVER;
                        bus.play_en <= 1'b0;
                        fall_cnt    <= '0;
                        pipe_cnt    <= '0;
                        hold_cnt    <= '0;
                        if (bus.score_bcd > bus.best_bcd)
                            bus.best_bcd <= bus.score_bcd;
                    end else begin
                        // A flap restarts gravity, suppressing any fall tick.
                        if (rise) begin
                            bus.flap <= 1'b1;
                            fall_cnt <= '0;
                        end else if (fall_cnt == FALL_LAST) begin
                            bus.fall_tick <= 1'b1;
                            fall_cnt      <= '0;
                        end else begin
                            fall_cnt <= fall_cnt + 1'b1;
                        end

                        if (pipe_cnt == PIPE_LAST) begin
                            bus.pipe_tick <= 1'b1;
                            pipe_cnt      <= '0;
                        end else begin
                            pipe_cnt <= pipe_cnt + 1'b1;
                        end

                        if (bus.pass)
                            bus.score_bcd <= bcd_inc(bus.score_bcd);
                    end
                end

                S_OVER: begin
                    if (hold_cnt == HOLD_MAX) begin
                        if (rise) begin
                            st            <= S_CLEAR;
                            bus.clear     <= 1'b1;
                            bus.score_bcd <= 8'h00;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
